// File: rtl/pmc_prog_loader_if.sv
// pmc_prog_loader_if: host CPU bus seen by the PMC program loader.
// Ports (as signals): pin_CS (active-low select), pin_NRD (1 = write),
// pin_BK (bank, loader answers on 0), pin_AB (13-bit address),
// db_in (write data), db_out/db_oe (read data and its drive enable).
// master = host side, slave = loader side.
interface pmc_prog_loader_if;
    logic        pin_CS;
    logic        pin_NRD;
    logic        pin_BK;
    logic [12:0] pin_AB;
    logic [7:0]  db_in;
    logic [7:0]  db_out;
    logic        db_oe;

    modport master (
        output pin_CS, pin_NRD, pin_BK, pin_AB, db_in,
        input  db_out, db_oe
    );

    modport slave (
        input  pin_CS, pin_NRD, pin_BK, pin_AB, db_in,
        output db_out, db_oe
    );
endinterface

// File: rtl/pmc_prog_loader.sv
// pmc_prog_loader: packs byte-wide host writes into WORD_W-bit words and
// writes them to a DEPTH-entry iram with auto-increment; holds run/start_pc.
// Ports:
//   pin_M12, pin_RST   clock, synchronous active-high reset
//   bus                host bus (pmc_prog_loader_if.slave)
//   iram_we/a/d        one-cycle write strobe, address, assembled word
//   iram_q             iram read data, combinational from iram_a
//   run, start_pc      control register outputs
//   ovf, err           sticky pointer-wrap and write-while-running flags
// Build option: define PMC_READBACK_EN to service host reads (NRD=0);
// without it reads are ignored and db_out/db_oe are tied low.
module pmc_prog_loader #(
    parameter int          WORD_W    = 36,
    parameter int          DEPTH     = 64,
    parameter int          AW        = 6,
    parameter logic [12:0] CTRL_ADDR = 13'h200,
    parameter logic [12:0] DATA_ADDR = 13'h000
) (
    input  logic              pin_M12,
    input  logic              pin_RST,
    pmc_prog_loader_if.slave  bus,
    output logic              iram_we,
    output logic [AW-1:0]     iram_a,
    output logic [WORD_W-1:0] iram_d,
    input  logic [WORD_W-1:0] iram_q,
    output logic              run,
    output logic [AW-1:0]     start_pc,
    output logic              ovf,
    output logic              err
);
    localparam int            B    = (WORD_W + 7) / 8;
    localparam int            BW   = 8 * B;
    localparam logic [2:0]    LAST = 3'(B - 1);
    localparam logic [AW-1:0] TOP  = AW'(DEPTH - 1);

    logic          cs_q;
    logic [2:0]    byte_cnt;
    logic [AW-1:0] word_ptr;
    logic [AW-1:0] commit_a;
    logic [AW-1:0] ptr_inc;
    logic [BW-1:0] shift;
    logic [BW-1:0] shift_n;
    logic [5:0]    sh;
    logic          acc;
    logic          ctrl_hit;
    logic          data_hit;
    logic          ctrl_wr;
    logic          data_wr;
    logic          data_rd;
    logic          advance;
    logic          last;
    logic          wrap;

    // An access is the first cycle CS is seen low after being seen high.
    assign acc      = cs_q & ~bus.pin_CS & ~bus.pin_BK;
    assign ctrl_hit = acc & (bus.pin_AB == CTRL_ADDR);
    assign data_hit = acc & (bus.pin_AB == DATA_ADDR);
    assign ctrl_wr  = ctrl_hit & bus.pin_NRD;
    assign data_wr  = data_hit & bus.pin_NRD & ~run;
    assign advance  = data_wr | data_rd;
    assign last     = byte_cnt == LAST;
    assign wrap     = word_ptr == TOP;
    assign ptr_inc  = wrap ? '0 : word_ptr + 1'b1;
    assign sh       = {byte_cnt, 3'b000};
    // Little-endian byte lane insert; bits past WORD_W fall off at commit.
    assign shift_n  = (shift & ~(BW'(8'hFF) << sh)) | (BW'(bus.db_in) << sh);
    assign iram_a   = iram_we ? commit_a : word_ptr;

    always_ff @(posedge pin_M12) begin
        if (pin_RST) begin
            cs_q     <= 1'b1;
            byte_cnt <= '0;
            word_ptr <= '0;
            commit_a <= '0;
            shift    <= '0;
            iram_we  <= 1'b0;
            iram_d   <= '0;
            run      <= 1'b0;
            start_pc <= '0;
            ovf      <= 1'b0;
            err      <= 1'b0;
        end else begin
            cs_q    <= bus.pin_CS;
            iram_we <= data_wr & last;
            if (data_hit & bus.pin_NRD & run)
                err <= 1'b1;
            if (data_wr)
                shift <= shift_n;
            if (advance)
                byte_cnt <= last ? 3'd0 : byte_cnt + 3'd1;
            if (advance & last)
                word_ptr <= ptr_inc;
            if (data_wr & last) begin
                commit_a <= word_ptr;
                iram_d   <= shift_n[WORD_W-1:0];
                if (wrap)
                    ovf <= 1'b1;
            end
            if (ctrl_wr) begin
                run      <= bus.db_in[7];
                start_pc <= AW'(bus.db_in[6:0]);
                word_ptr <= '0;
                byte_cnt <= '0;
                ovf      <= 1'b0;
                err      <= 1'b0;
            end
        end
    end

`ifdef PMC_READBACK_EN
    logic [BW-1:0] q_pad;
    logic [7:0]    rd_byte;

    // Reads walk the same byte/word pointers as writes but never strobe
    // iram_we and never flag a wrap; they are held off while running.
    assign data_rd = data_hit & ~bus.pin_NRD & ~run;
    assign q_pad   = BW'(iram_q);
    assign rd_byte = 8'(q_pad >> sh);

    always_ff @(posedge pin_M12) begin
        if (pin_RST) begin
            bus.db_out <= '0;
            bus.db_oe  <= 1'b0;
        end else if (ctrl_hit & ~bus.pin_NRD) begin
            bus.db_out <= {run, ovf, err, 2'b00, byte_cnt};
            bus.db_oe  <= 1'b1;
        end else if (data_rd) begin
            bus.db_out <= rd_byte;
            bus.db_oe  <= 1'b1;
        end else if (bus.pin_CS) begin
            bus.db_oe  <= 1'b0;
        end
    end
`else
    logic unused_q;

    assign data_rd    = 1'b0;
    assign bus.db_out = '0;
    assign bus.db_oe  = 1'b0;
    assign unused_q   = ^iram_q;
`endif
endmodule

// File: tb/tb_pmc_prog_loader.sv
// tb_pmc_prog_loader: randomized and directed checks of pmc_prog_loader
// against a byte-list / word-array reference model.
module tb_pmc_prog_loader;
    localparam int          WORD_W = 36;
    localparam int          DEPTH  = 64;
    localparam int          AW     = 6;
    localparam int          B      = (WORD_W + 7) / 8;
    localparam logic [12:0] CTRL   = 13'h200;
    localparam logic [12:0] DATA   = 13'h000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              iram_we;
    logic [AW-1:0]     iram_a;
    logic [WORD_W-1:0] iram_d;
    logic [WORD_W-1:0] iram_q;
    logic              run;
    logic [AW-1:0]     start_pc;
    logic              ovf;
    logic              err;
    logic [WORD_W-1:0] mem [DEPTH];

    pmc_prog_loader_if bus();

    pmc_prog_loader #(
        .WORD_W(WORD_W), .DEPTH(DEPTH), .AW(AW), .CTRL_ADDR(CTRL), .DATA_ADDR(DATA)
    ) dut (
        .pin_M12(clk), .pin_RST(rst), .bus(bus),
        .iram_we(iram_we), .iram_a(iram_a), .iram_d(iram_d), .iram_q(iram_q),
        .run(run), .start_pc(start_pc), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    assign iram_q = mem[iram_a];
    always @(posedge clk) if (iram_we) mem[iram_a] <= iram_d;

    int n_chk = 0;
    int n_pass = 0;
    int n_we = 0;
    always @(negedge clk) if (iram_we === 1'b1) n_we++;

    // Reference model: byte count within the current word, word pointer,
    // flags, the bytes gathered so far and the expected iram contents.
    bit                m_run, m_ovf, m_err;
    int                m_pc, m_ptr, m_bc;
    logic [7:0]        m_cur [8];
    logic [WORD_W-1:0] m_mem [DEPTH];

    logic              s_we, s_we2, s_oe, s_oe2;
    logic [AW-1:0]     s_a, s_ptr;
    logic [WORD_W-1:0] s_d;
    logic [7:0]        s_out;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // One bus access starting at a negedge: CS low for 1+hold cycles, then high.
    task automatic bus_acc(input bit nrd, input bit bk, input logic [12:0] ab,
                           input logic [7:0] d, input int hold);
        bus.pin_CS = 1'b0; bus.pin_NRD = nrd; bus.pin_BK = bk; bus.pin_AB = ab; bus.db_in = d;
        @(negedge clk);
        s_we = iram_we; s_a = iram_a; s_d = iram_d; s_oe = bus.db_oe; s_out = bus.db_out;
        repeat (hold) @(negedge clk);
        bus.pin_CS = 1'b1;
        @(negedge clk);
        s_we2 = iram_we; s_ptr = iram_a; s_oe2 = bus.db_oe;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".run"}, run, m_run);
        chk({tag, ".pc"}, start_pc, m_pc);
        chk({tag, ".ovf"}, ovf, m_ovf);
        chk({tag, ".err"}, err, m_err);
        chk({tag, ".ptr"}, s_ptr, m_ptr);
    endtask

    task automatic ctrl_wr(input logic [7:0] v);
        int w0;
        w0 = n_we;
        m_run = v[7]; m_pc = int'(v[6:0]) % (1 << AW);
        m_ptr = 0; m_bc = 0; m_ovf = 0; m_err = 0;
        bus_acc(1'b1, 1'b0, CTRL, v, 0);
        chk("ctrl.we_cnt", n_we - w0, 0);
        check_state("ctrl");
    endtask

    task automatic wr(input logic [7:0] b, input bit bk = 0,
                      input logic [12:0] ab = DATA, input int hold = 0);
        int w0, ea;
        bit commit;
        logic [63:0] word;
        w0 = n_we; ea = 0; commit = 0; word = 0;
        if (!bk && ab == DATA) begin
            if (m_run) m_err = 1;
            else begin
                m_cur[m_bc] = b;
                m_bc++;
                if (m_bc == B) begin
                    for (int k = 0; k < B; k++) word |= 64'(m_cur[k]) << (8 * k);
                    word &= (64'd1 << WORD_W) - 64'd1;
                    ea = m_ptr;
                    m_mem[m_ptr] = word[WORD_W-1:0];
                    commit = 1;
                    m_bc = 0;
                    if (m_ptr == DEPTH - 1) begin m_ptr = 0; m_ovf = 1; end
                    else m_ptr++;
                end
            end
        end
        bus_acc(1'b1, bk, ab, b, hold);
        chk("wr.we", s_we, commit);
        if (commit) begin
            chk("wr.addr", s_a, ea);
            chk("wr.data", s_d, word);
        end
        chk("wr.we_cnt", n_we - w0, commit);
        chk("wr.we_off", s_we2, 0);
        chk("wr.oe", s_oe, 0);
        check_state("wr");
    endtask

    task automatic rd(input logic [12:0] ab);
        logic [7:0] eo;
        bit eoe;
        eo = 0; eoe = 0;
`ifdef PMC_READBACK_EN
        eoe = 1;
        if (ab == CTRL) eo = {m_run, m_ovf, m_err, 2'b00, 3'(m_bc)};
        else begin
            eo = 8'(m_mem[m_ptr] >> (8 * m_bc));
            m_bc++;
            if (m_bc == B) begin
                m_bc = 0;
                m_ptr = (m_ptr + 1) % DEPTH;
            end
        end
`endif
        bus_acc(1'b0, 1'b0, ab, 8'h00, 0);
        chk("rd.out", s_out, eo);
        chk("rd.oe", s_oe, eoe);
        chk("rd.oe_off", s_oe2, 0);
        check_state("rd");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_run = 0; m_ovf = 0; m_err = 0; m_pc = 0; m_ptr = 0; m_bc = 0;
        for (int k = 0; k < 8; k++) m_cur[k] = 8'h00;
        chk("rst.run", run, 0);
        chk("rst.pc", start_pc, 0);
        chk("rst.ovf", ovf, 0);
        chk("rst.err", err, 0);
        chk("rst.we", iram_we, 0);
        chk("rst.a", iram_a, 0);
        chk("rst.d", iram_d, 0);
        chk("rst.oe", bus.db_oe, 0);
        chk("rst.out", bus.db_out, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pin_CS = 1'b1; bus.pin_NRD = 1'b1; bus.pin_BK = 1'b0;
        bus.pin_AB = '0; bus.db_in = '0;
        for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; m_mem[i] = '0; end
        repeat (3) @(negedge clk);
        do_reset();

        ctrl_wr(8'h00);
        wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04); wr(8'h0F);
        chk("first.data", s_d, 36'hF04030201);
        chk("first.ptr", s_ptr, 1);

        ctrl_wr(8'h00);
        for (int i = 0; i < 320; i++) wr(8'($urandom));
        chk("fill.ovf", ovf, 1);
        for (int i = 0; i < 5; i++) wr(8'($urandom));
        chk("wrap.addr", s_a, 0);

        ctrl_wr(8'h81);
        wr(8'h55);
        chk("run.err", err, 1);
        ctrl_wr(8'h00);

        wr(8'h11); wr(8'h22); wr(8'h33);
        do_reset();
        wr(8'h0A); wr(8'h0B); wr(8'h0C); wr(8'h0D); wr(8'h0E);
        chk("rst_word.data", s_d, 36'hE0D0C0B0A);
        chk("rst_word.addr", s_a, 0);

        ctrl_wr(8'h00);
        wr(8'h89); wr(8'h67); wr(8'h45); wr(8'h23); wr(8'h01);
        ctrl_wr(8'h00);
        for (int i = 0; i < 5; i++) rd(DATA);
        rd(CTRL);

        ctrl_wr(8'h00);
        wr(8'hAA, 1'b0, DATA, 9);
        for (int i = 0; i < 4; i++) wr(8'($urandom));

        ctrl_wr(8'h00);
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0: ctrl_wr({1'($urandom_range(0, 5) == 0), 7'($urandom)});
                1: wr(8'($urandom), 1'b0, 13'h001 + 13'($urandom_range(0, 100)), 0);
                2: wr(8'($urandom), 1'b1, DATA, 0);
                default: wr(8'($urandom), 1'b0, DATA, $urandom_range(0, 2));
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
